// File: rtl/dataset_stream_source.sv
// Dataset replay source: holds SIZE input/teacher entries and streams them for EPOCHS epochs
// on two independent valid/ready channels (teacher channels zero-extended to WT bits).
module dataset_stream_source #(
    parameter int    SIZE   = 3,
    parameter int    NI     = 3,
    parameter int    NO     = 2,
    parameter int    WF     = 8,
    parameter int    WT     = 11,
    parameter int    EPOCHS = 1,
    parameter string BURST  = "yes",
    localparam int   AW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iWe,
    input  logic [AW-1:0]         iWAddr,
    input  logic [(NI+NO)*WF-1:0] iWData,
    input  logic                  iStart,
    input  logic                  iTeach,
    output logic                  oBusy,
    output logic                  oDone,
    output logic                  oValid_BM_Input,
    input  logic                  iReady_BM_Input,
    output logic [NI*WF-1:0]      oData_BM_Input,
    output logic                  oValid_BM_Teacher,
    input  logic                  iReady_BM_Teacher,
    output logic [NO*WT-1:0]      oData_BM_Teacher
);

    localparam int              ENTRY_W  = (NI + NO) * WF;
    localparam int              EW       = (EPOCHS > 1) ? $clog2(EPOCHS) : 1;
    localparam bit              GAPS     = (BURST == "no");
    localparam logic [AW-1:0]   PTR_LAST = AW'(SIZE - 1);
    localparam logic [EW-1:0]   EP_LAST  = EW'(EPOCHS - 1);
    localparam logic [AW:0]     SIZE_W   = (AW + 1)'(SIZE);

    typedef enum logic [1:0] {IDLE, RUN, DONE} top_t;
    typedef enum logic [1:0] {ACTIVE, GAP, FINISHED} sub_t;

    top_t state, state_next;
    sub_t sub [2];
    sub_t sub_next [2];
    logic [AW-1:0] ptr [2];
    logic [AW-1:0] ptr_next [2];
    logic [EW-1:0] epoch [2];
    logic [EW-1:0] epoch_next [2];
    logic [1:0] ready, valid, fire, last;

    logic [ENTRY_W-1:0] mem [SIZE];
    logic [ENTRY_W-1:0] start_entry;
    logic [NI*WF-1:0]   data_in;
    logic [NO*WT-1:0]   data_teach;

    function automatic logic [NO*WT-1:0] widen(input logic [NO*WF-1:0] t);
        logic [NO*WT-1:0] r;
        r = '0;
        for (int k = 0; k < NO; k++) begin
            r[k*WT +: WT] = WT'(t[k*WF +: WF]);
        end
        return r;
    endfunction

    assign ready = {iReady_BM_Teacher, iReady_BM_Input};

    // Index 0 is the input stream, index 1 the teacher stream.
    always_comb begin
        valid = '0;
        fire  = '0;
        last  = '0;
        for (int s = 0; s < 2; s++) begin
            valid[s] = (state == RUN) && (sub[s] == ACTIVE);
            fire[s]  = valid[s] && ready[s];
            last[s]  = (ptr[s] == PTR_LAST) && (EPOCHS != 0) && (epoch[s] == EP_LAST);
        end
    end

    always_comb begin
        state_next = state;
        for (int s = 0; s < 2; s++) begin
            sub_next[s]   = sub[s];
            ptr_next[s]   = ptr[s];
            epoch_next[s] = epoch[s];
        end
        case (state)
            IDLE: begin
                if (iStart) begin
                    state_next = RUN;
                    for (int s = 0; s < 2; s++) begin
                        ptr_next[s]   = '0;
                        epoch_next[s] = '0;
                        sub_next[s]   = ((s == 1) && !iTeach) ? FINISHED : ACTIVE;
                    end
                end
            end
            RUN: begin
                for (int s = 0; s < 2; s++) begin
                    case (sub[s])
                        ACTIVE: begin
                            if (fire[s]) begin
                                if (ptr[s] == PTR_LAST) begin
                                    ptr_next[s]   = '0;
                                    epoch_next[s] = epoch[s] + 1'b1;
                                end else begin
                                    ptr_next[s] = ptr[s] + 1'b1;
                                end
                                sub_next[s] = last[s] ? FINISHED : (GAPS ? GAP : ACTIVE);
                            end
                        end
                        GAP:     sub_next[s] = ACTIVE;
                        default: sub_next[s] = sub[s];
                    endcase
                end
                if ((sub_next[0] == FINISHED) && (sub_next[1] == FINISHED)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= IDLE;
            for (int s = 0; s < 2; s++) begin
                sub[s]   <= FINISHED;
                ptr[s]   <= '0;
                epoch[s] <= '0;
            end
        end else begin
            state <= state_next;
            for (int s = 0; s < 2; s++) begin
                sub[s]   <= sub_next[s];
                ptr[s]   <= ptr_next[s];
                epoch[s] <= epoch_next[s];
            end
        end
    end

    // Dataset is deliberately left out of reset so it survives an aborted run.
    always_ff @(posedge iCLK) begin
        if ((state == IDLE) && iWe && ({1'b0, iWAddr} < SIZE_W)) begin
            mem[iWAddr] <= iWData;
        end
    end

    assign start_entry = (iWe && (iWAddr == '0)) ? iWData : mem[0];

    // Next entry is fetched on the accepting edge, so a gap cycle needs no extra fetch.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            data_in    <= '0;
            data_teach <= '0;
        end else if ((state == IDLE) && iStart) begin
            data_in    <= start_entry[NI*WF-1:0];
            data_teach <= widen(start_entry[ENTRY_W-1:NI*WF]);
        end else begin
            if (fire[0] && !last[0]) begin
                data_in <= mem[ptr_next[0]][NI*WF-1:0];
            end
            if (fire[1] && !last[1]) begin
                data_teach <= widen(mem[ptr_next[1]][ENTRY_W-1:NI*WF]);
            end
        end
    end

    assign oValid_BM_Input   = valid[0];
    assign oValid_BM_Teacher = valid[1];
    assign oData_BM_Input    = data_in;
    assign oData_BM_Teacher  = data_teach;
    assign oBusy             = (state == RUN);
    assign oDone             = (state == DONE);

endmodule

// File: tb/tb_dataset_stream_source.sv
// Bench for dataset_stream_source: three configurations driven in lockstep against a
// beat-counting reference model, with random backpressure and directed corner cases.
module tb_dataset_stream_source;

    logic iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    logic        iRST, iWe, iStart, iTeach;
    logic [1:0]  iWAddr;
    logic [39:0] iWData;
    logic [2:0]  ri, rt, vi, vt, busy, done;
    logic [23:0] di [3];
    logic [21:0] dt [3];

    dataset_stream_source #(.EPOCHS(1), .BURST("yes")) u0 (
        .iCLK(iCLK), .iRST(iRST), .iWe(iWe), .iWAddr(iWAddr), .iWData(iWData),
        .iStart(iStart), .iTeach(iTeach), .oBusy(busy[0]), .oDone(done[0]),
        .oValid_BM_Input(vi[0]), .iReady_BM_Input(ri[0]), .oData_BM_Input(di[0]),
        .oValid_BM_Teacher(vt[0]), .iReady_BM_Teacher(rt[0]), .oData_BM_Teacher(dt[0]));

    dataset_stream_source #(.EPOCHS(1), .BURST("no")) u1 (
        .iCLK(iCLK), .iRST(iRST), .iWe(iWe), .iWAddr(iWAddr), .iWData(iWData),
        .iStart(iStart), .iTeach(iTeach), .oBusy(busy[1]), .oDone(done[1]),
        .oValid_BM_Input(vi[1]), .iReady_BM_Input(ri[1]), .oData_BM_Input(di[1]),
        .oValid_BM_Teacher(vt[1]), .iReady_BM_Teacher(rt[1]), .oData_BM_Teacher(dt[1]));

    dataset_stream_source #(.EPOCHS(2), .BURST("yes")) u2 (
        .iCLK(iCLK), .iRST(iRST), .iWe(iWe), .iWAddr(iWAddr), .iWData(iWData),
        .iStart(iStart), .iTeach(iTeach), .oBusy(busy[2]), .oDone(done[2]),
        .oValid_BM_Input(vi[2]), .iReady_BM_Input(ri[2]), .oData_BM_Input(di[2]),
        .oValid_BM_Teacher(vt[2]), .iReady_BM_Teacher(rt[2]), .oData_BM_Teacher(dt[2]));

    // Reference model: per instance a run phase (0 idle, 1 run, 2 done) and, per stream,
    // the number of beats delivered so far; entry index is simply beats mod SIZE.
    int          m_epochs [3] = '{1, 1, 2};
    bit          m_gaps   [3] = '{0, 1, 0};
    int          mphase [3];
    int          beats  [3][2];
    bit          gap    [3][2];
    bit          fin    [3][2];
    logic [39:0] mem    [3][3];

    int passes = 0;
    int total  = 0;
    bit rdy_rand = 0;
    int teach_stall = 0;

    function automatic logic [21:0] fmt_t(input logic [39:0] e);
        logic [21:0] r;
        r = '0;
        for (int k = 0; k < 2; k++) r[k*11 +: 11] = {3'b000, e[24 + k*8 +: 8]};
        return r;
    endfunction

    task automatic chk(input string tag, input int inst, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s u%0d: observed %h expected %h", tag, inst, obs, exp);
    endtask

    task automatic check_reset();
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid_in", i, 64'(vi[i]), 64'd0);
            chk("rst_valid_t", i, 64'(vt[i]), 64'd0);
            chk("rst_busy", i, 64'(busy[i]), 64'd0);
            chk("rst_done", i, 64'(done[i]), 64'd0);
            chk("rst_data_in", i, 64'(di[i]), 64'd0);
            chk("rst_data_t", i, 64'(dt[i]), 64'd0);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mphase[i] = 0;
            for (int s = 0; s < 2; s++) begin
                beats[i][s] = 0;
                gap[i][s]   = 0;
                fin[i][s]   = 1;
            end
        end
    endtask

    task automatic check_output();
        bit exp_v;
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 2; s++) begin
                exp_v = (mphase[i] == 1) && !fin[i][s] && !gap[i][s];
                if (s == 0) begin
                    chk("valid_in", i, 64'(vi[i]), 64'(exp_v));
                    if (exp_v) chk("data_in", i, 64'(di[i]), 64'(mem[i][beats[i][0] % 3][23:0]));
                end else begin
                    chk("valid_t", i, 64'(vt[i]), 64'(exp_v));
                    if (exp_v) chk("data_t", i, 64'(dt[i]), 64'(fmt_t(mem[i][beats[i][1] % 3])));
                end
            end
            chk("busy", i, 64'(busy[i]), 64'(mphase[i] == 1));
            chk("done", i, 64'(done[i]), 64'(mphase[i] == 2));
        end
    endtask

    task automatic model_edge(input bit start, input bit teach, input bit we,
                              input logic [1:0] waddr, input logic [39:0] wdata);
        bit rdy;
        for (int i = 0; i < 3; i++) begin
            case (mphase[i])
                0: begin
                    if (we && waddr < 2'd3) mem[i][waddr] = wdata;
                    if (start) begin
                        mphase[i] = 1;
                        for (int s = 0; s < 2; s++) begin
                            beats[i][s] = 0;
                            gap[i][s]   = 0;
                        end
                        fin[i][0] = 0;
                        fin[i][1] = !teach;
                    end
                end
                1: begin
                    for (int s = 0; s < 2; s++) begin
                        rdy = (s == 0) ? ri[i] : rt[i];
                        if (gap[i][s]) gap[i][s] = 0;
                        else if (!fin[i][s] && rdy) begin
                            beats[i][s]++;
                            if (beats[i][s] == 3 * m_epochs[i]) fin[i][s] = 1;
                            else if (m_gaps[i]) gap[i][s] = 1;
                        end
                    end
                    if (fin[i][0] && fin[i][1]) mphase[i] = 2;
                end
                default: mphase[i] = 0;
            endcase
        end
    endtask

    task automatic apply_stimulus(input bit start, input bit teach, input bit we,
                                  input logic [1:0] waddr, input logic [39:0] wdata);
        @(negedge iCLK);
        iStart = start;
        iTeach = teach;
        iWe    = we;
        iWAddr = waddr;
        iWData = wdata;
        for (int i = 0; i < 3; i++) begin
            ri[i] = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            rt[i] = (teach_stall > 0) ? 1'b0 : (rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1);
        end
        if (teach_stall > 0) teach_stall--;
        check_output();
        model_edge(start, teach, we, waddr, wdata);
    endtask

    function automatic bit all_idle();
        return (mphase[0] == 0) && (mphase[1] == 0) && (mphase[2] == 0);
    endfunction

    task automatic run_to_idle(input int budget);
        int n = 0;
        while (!all_idle() && n < budget) begin
            apply_stimulus(0, 0, 0, 2'd0, 40'd0);
            n++;
        end
        if (!all_idle()) begin
            $display("[TB] FAIL run_budget: run still active after %0d cycles", n);
            $fatal(1, "[TB] run budget exhausted");
        end
        apply_stimulus(0, 0, 0, 2'd0, 40'd0);
        apply_stimulus(0, 0, 0, 2'd0, 40'd0);
    endtask

    task automatic reset_now();
        @(negedge iCLK);
        iStart = 0;
        iWe    = 0;
        iRST   = 0;
        #1;
        check_reset();
        model_reset();
        @(negedge iCLK);
        iRST = 1;
    endtask

    initial begin
        iRST = 0; iWe = 0; iStart = 0; iTeach = 0; iWAddr = '0; iWData = '0;
        ri = '1; rt = '1;
        model_reset();
        #1;
        $display("[TB] reset state");
        check_reset();
        @(negedge iCLK);
        iRST = 1;

        $display("[TB] load dataset");
        apply_stimulus(0, 0, 1, 2'd0, {16'h0A0B, 24'h010203});
        apply_stimulus(0, 0, 1, 2'd1, {16'h0C0D, 24'h040506});
        apply_stimulus(0, 0, 1, 2'd2, {16'h0E0F, 24'h070809});

        $display("[TB] full-rate run, teacher enabled");
        apply_stimulus(1, 1, 0, 2'd0, 40'd0);
        run_to_idle(60);

        $display("[TB] random backpressure, teacher stalled");
        rdy_rand = 1;
        teach_stall = 10;
        apply_stimulus(1, 1, 0, 2'd0, 40'd0);
        run_to_idle(300);

        $display("[TB] teacher disabled");
        rdy_rand = 0;
        apply_stimulus(1, 0, 0, 2'd0, 40'd0);
        run_to_idle(60);

        $display("[TB] write and start during run are ignored");
        apply_stimulus(1, 1, 0, 2'd0, 40'd0);
        apply_stimulus(1, 1, 1, 2'd0, 40'hFF_FFFF_FFFF);
        apply_stimulus(1, 0, 1, 2'd1, 40'h12_3456_789A);
        run_to_idle(60);

        $display("[TB] out-of-range write is ignored");
        apply_stimulus(0, 0, 1, 2'd3, 40'hAA_BBCC_DDEE);
        apply_stimulus(1, 1, 0, 2'd0, 40'd0);
        run_to_idle(60);

        $display("[TB] write and start in the same idle cycle");
        apply_stimulus(1, 1, 1, 2'd0, {16'h3344, 24'h55AA11});
        run_to_idle(60);

        $display("[TB] reset mid-epoch");
        apply_stimulus(1, 1, 0, 2'd0, 40'd0);
        apply_stimulus(0, 0, 0, 2'd0, 40'd0);
        apply_stimulus(0, 0, 0, 2'd0, 40'd0);
        reset_now();
        for (int k = 0; k < 3; k++) apply_stimulus(0, 0, 0, 2'd0, 40'd0);
        apply_stimulus(1, 1, 0, 2'd0, 40'd0);
        run_to_idle(60);

        $display("[TB] randomized runs");
        for (int r = 0; r < 6; r++) begin
            rdy_rand = 1;
            teach_stall = $urandom_range(0, 10);
            apply_stimulus(0, 0, 1, 2'($urandom_range(0, 3)), {$urandom(), 8'($urandom())});
            apply_stimulus(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           2'($urandom_range(0, 3)), {$urandom(), 8'($urandom())});
            run_to_idle(300);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
